vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
- REQ-001 The block SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
- REQ-002 The block SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
- REQ-003 The block SHALL have parameter H_SYNC, default 96: horizontal sync width, in pixels.
- REQ-004 The block SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
- REQ-005 The block SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing, in lines.
- REQ-006 The block SHALL have parameter SYNC_POL, default 0: asserted sync level (0 = active-low).
- REQ-007 The block SHALL have port clk, input, 1 bit: single system clock (100 MHz); all logic on its rising edge.
- REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-009 The block SHALL have port pix_en, input, 1 bit: pixel strobe, one clk wide, from the 25 MHz pixel divider.
- REQ-010 The block SHALL have port rgb_in, input, 12 bits: pixel colour for the current (hcnt,vcnt).
- REQ-011 The block SHALL have port hcnt, output, 10 bits: horizontal position, 0..H_TOTAL-1.
- REQ-012 The block SHALL have port vcnt, output, 10 bits: vertical position, 0..V_TOTAL-1.
- REQ-013 The block SHALL have port active, output, 1 bit: (hcnt,vcnt) lies inside the visible area.
- REQ-014 The block SHALL have ports frame_start and line_start, outputs, 1 bit each: single-clk pulses.
- REQ-015 The block SHALL have ports hsync and vsync, outputs, 1 bit each: sync signals to the connector.
- REQ-016 The block SHALL have port rgb_out, output, 12 bits: blanked pixel data to the connector.

Function
- REQ-017 The block SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL likewise (525).
- REQ-018 Counters SHALL advance only on clk edges with pix_en=1; with pix_en=0 all registered outputs hold, except the pulses, which return to 0.
- REQ-019 On each pix_en, hcnt SHALL increment; at H_TOTAL-1 it wraps to 0 and vcnt increments.
- REQ-020 vcnt SHALL wrap from V_TOTAL-1 to 0 only when hcnt wraps at the same time.
- REQ-021 active SHALL be a register updated on the same edge as the counters, equal to (hcnt<H_ACTIVE && vcnt<V_ACTIVE) for the new counter values.
- REQ-022 An internal stage-0 horizontal sync SHALL be asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751), registered alongside the counters.
- REQ-023 An internal stage-0 vertical sync SHALL be asserted for 490 <= vcnt <= 491 by the same rule.
- REQ-024 line_start SHALL pulse high for exactly one clk on the edge where hcnt becomes 0.
- REQ-025 frame_start SHALL pulse high for exactly one clk on the edge where (hcnt,vcnt) becomes (0,0); line_start also pulses on that edge.
- REQ-026 Stage 1: on each pix_en, rgb_out SHALL take rgb_in if stage-0 active=1, else 12'h000.
- REQ-027 Stage 1: on the same pix_en, hsync/vsync SHALL take the stage-0 syncs mapped to SYNC_POL, so rgb_out, hsync and vsync align and lag hcnt/vcnt by exactly one pixel.
- REQ-028 Inactive sync level SHALL be ~SYNC_POL.
- REQ-029 The block SHALL add no latency beyond REQ-027 and SHALL be independent of pix_en spacing; back-to-back pix_en on consecutive clks remains legal.

Reset
- REQ-030 While rst=1, the block SHALL force: hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, active=0, stage-0 syncs deasserted, hsync=vsync=~SYNC_POL, rgb_out=0, frame_start=line_start=0.
- REQ-031 rst SHALL take priority over a simultaneous pix_en.
- REQ-032 The first pix_en after reset release SHALL move the counters to (0,0) and raise frame_start.
- REQ-033 rst asserted mid-frame SHALL abandon the frame immediately with no partial-line completion.

Verification
- REQ-034 Reset release, then pix_en every 4th clk: first strobe -> hcnt=0, vcnt=0, active=1, frame_start=1 and line_start=1 for one clk.
- REQ-035 Run one full line: hsync low for exactly 96 strobes; first low output on the strobe after hcnt=656; line_start period = 800 strobes (3200 clks).
- REQ-036 Run a full frame: vsync low for exactly 2*800 strobes; frame_start period = 420000 strobes; active high for 640 strobes per line on 480 lines.
- REQ-037 Drive rgb_in = {hcnt[3:0],vcnt[3:0],4'hA}: rgb_out equals the previous strobe's value when active was 1, else 000; at hcnt=640 the next strobe gives rgb_out=000.
- REQ-038 Assert rst at hcnt=300, vcnt=200 together with pix_en -> next clk shows reset values (799,524), hsync=vsync=1; hold pix_en=0 for 10 clks -> all outputs stable and pulses stay 0.
- REQ-039 Hold pix_en=1 continuously: counters step every clk, and wrap 799->0 and 524->0 occur on the same edge with frame_start=1.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a pixel strobe,
// sync pulses and blanked colour delayed one pixel so they line up at the connector.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hcnt,
  output logic [9:0]  vcnt,
  output logic        active,
  output logic        frame_start,
  output logic        line_start,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       POL    = (SYNC_POL != 0);

  logic       hs0, vs0;
  logic       h_wrap, v_wrap;
  logic [9:0] h_nxt, v_nxt;

  // Reset parks the counters on the last pixel so the first strobe lands on (0,0).
  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = h_wrap && (vcnt == V_LAST);
  assign h_nxt  = h_wrap ? 10'd0 : hcnt + 10'd1;
  assign v_nxt  = v_wrap ? 10'd0 : (h_wrap ? vcnt + 10'd1 : vcnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= H_LAST;
      vcnt        <= V_LAST;
      active      <= 1'b0;
      hs0         <= 1'b0;
      vs0         <= 1'b0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      rgb_out     <= 12'h000;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (pix_en) begin
        hcnt        <= h_nxt;
        vcnt        <= v_nxt;
        active      <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hs0         <= (h_nxt >= HS_BEG) && (h_nxt < HS_END);
        vs0         <= (v_nxt >= VS_BEG) && (v_nxt < VS_END);
        line_start  <= h_wrap;
        frame_start <= v_wrap;
        // Stage 1 reads the pre-edge stage-0 values, giving the one-pixel lag.
        hsync       <= hs0 ? POL : ~POL;
        vsync       <= vs0 ? POL : ~POL;
        rgb_out     <= active ? rgb_in : 12'h000;
      end
    end
  end
endmodule
